id_ex_pipe: RTL
===============

# id_ex_pipe

Parametrised ID→EX pipeline stage replacing the fixed-width, always-enabled ID/EX register. It carries the decoded instruction payload (ALU op, ALU select, two operands, write address, write-enable) with valid/ready flow control, a two-entry skid buffer so backpressure never forms a combinational ready path, and a synchronous flush for branch/exception squash. It sits between the decode stage and the execute stage of the openMIPS core.

## Interface
Parameters:
- OP_W, 8, ALU op width
- SEL_W, 3, ALU select width
- DATA_W, 32, operand width
- ADDR_W, 5, register write-address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all held and incoming entries
- id_valid  in  1  decode presents a payload
- id_ready  out  1  stage can accept; registered, no combinational path from ex_ready
- id_alu_op / id_alu_sel  in  OP_W / SEL_W  decoded op / select
- id_reg0 / id_reg1  in  DATA_W  operands
- id_waddr  in  ADDR_W  destination register
- id_wreg  in  1  destination write-enable
- ex_valid  out  1  payload valid to execute
- ex_ready  in  1  execute consumes payload this cycle
- ex_alu_op / ex_alu_sel / ex_reg0 / ex_reg1 / ex_waddr  out  as inputs  payload to execute
- ex_wreg  out  1  write-enable, forced 0 whenever ex_valid is 0 (bubble = NOP)

## Operation
- Two entries: MAIN (drives ex_* outputs) and SKID. State encoded by valid bits: EMPTY (neither), ONE (MAIN only), FULL (MAIN+SKID). SKID never valid while MAIN is invalid.
- Accept = id_valid & id_ready; consume = ex_valid & ex_ready.
- id_ready = !skid_valid (flop output).
- EMPTY: accept → ONE, payload into MAIN.
- ONE: accept & consume → ONE, MAIN reloaded; accept only → FULL, payload into SKID; consume only → EMPTY.
- FULL: id_ready=0; consume → ONE, SKID moves to MAIN; otherwise hold.
- flush=1: next state EMPTY regardless of accept/consume; incoming payload that cycle is dropped. flush overrides everything except reset.
- Payload registers load only on accept/move; they hold otherwise (no zeroing on consume). Only valid bits and ex_wreg gate visibility.
- No arithmetic; payload is passed bit-exact.

## Timing
- Reset (rst_=0, async): ex_valid=0, skid_valid=0, id_ready=1, ex_wreg=0, all ex_* payload outputs 0, SKID payload 0.
- Latency: accepted payload appears on ex_* the next cycle when stage was EMPTY or MAIN consumed the same cycle.
- Throughput: one transfer per cycle with ex_ready held high.
- Backpressure: after ex_ready drops, at most one further payload is accepted (into SKID); id_ready falls one cycle later.
- Reset asserted mid-transfer: state to EMPTY immediately, no payload lost accounting required.
- Simultaneous flush & consume: consume is honoured by execute in that cycle; stage is EMPTY next cycle.

## Structure
- Package id_ex_pkg: default width localparams and a packed payload typedef {alu_op, alu_sel, reg0, reg1, waddr, wreg} (81 bits at defaults).
- One generic sub-module pipe_skid (parameter W, payload width; valid/ready/flush; two entries) holding all sequential logic; id_ex_pipe packs/unpacks the payload and applies ex_wreg masking.

## Test plan
- Reset: hold rst_=0 with random inputs → ex_valid=0, ex_wreg=0, ex_reg0=0, id_ready=1; release, id_valid=1 reg0=0x1234_5678 → next cycle ex_valid=1, ex_reg0=0x1234_5678.
- Streaming: 8 back-to-back payloads (reg0=1..8) with ex_ready=1 → ex_reg0 sequence 1..8 on consecutive cycles, no gaps.
- Backpressure: ex_ready=0 for 3 cycles during stream → exactly two payloads held, id_ready=0 from second cycle; on release, order preserved, none dropped or duplicated.
- Flush in FULL: flush=1 with id_valid=1 → next cycle ex_valid=0, ex_wreg=0, id_ready=1; flushed payloads never appear.
- Bubble masking: id_wreg=1 waddr=5 consumed, then id_valid=0 → ex_valid=0 and ex_wreg=0 while ex_waddr still reads 5.
- Async reset mid-stream in FULL: rst_ pulse between edges → outputs zero immediately, stage accepts fresh payload after release.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared widths, payload layout and skid-buffer state encoding for the ID->EX stage.
package id_ex_pkg;

  localparam int OP_W_DEF   = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   alu_op;
    logic [SEL_W_DEF-1:0]  alu_sel;
    logic [DATA_W_DEF-1:0] reg0;
    logic [DATA_W_DEF-1:0] reg1;
    logic [ADDR_W_DEF-1:0] waddr;
    logic                  wreg;
  } id_ex_payload_t;

  localparam int PAYLOAD_W_DEF = $bits(id_ex_payload_t);

  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid.sv
// Generic two-entry valid/ready pipeline register with skid entry and synchronous flush.
module pipe_skid
  import id_ex_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output skid_state_e  state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and in_ready is decoded from registered state only.
  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         accept, consume;
  logic         load_main, load_skid, move_skid;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign state     = state_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_d   = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash drops everything held plus the payload offered this cycle.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) main_q <= in_data;
      else if (move_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage: packs the decoded instruction, buffers it in pipe_skid, masks wreg on bubbles.
module id_ex_pipe
  import id_ex_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [SEL_W-1:0]  id_alu_sel,
  input  logic [DATA_W-1:0] id_reg0,
  input  logic [DATA_W-1:0] id_reg1,
  input  logic [ADDR_W-1:0] id_waddr,
  input  logic              id_wreg,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [SEL_W-1:0]  ex_alu_sel,
  output logic [DATA_W-1:0] ex_reg0,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [ADDR_W-1:0] ex_waddr,
  output logic              ex_wreg,
  output logic [1:0]        stage_state
);

  typedef struct packed {
    logic [OP_W-1:0]   alu_op;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] reg0;
    logic [DATA_W-1:0] reg1;
    logic [ADDR_W-1:0] waddr;
    logic              wreg;
  } payload_t;

  localparam int W = $bits(payload_t);

  payload_t    in_p, out_p;
  skid_state_e skid_state;

  assign in_p = {id_alu_op, id_alu_sel, id_reg0, id_reg1, id_waddr, id_wreg};

  pipe_skid #(.W(W)) u_skid (
    .clk       (clk),
    .rst_      (rst_),
    .flush     (flush),
    .in_valid  (id_valid),
    .in_ready  (id_ready),
    .in_data   (in_p),
    .out_valid (ex_valid),
    .out_ready (ex_ready),
    .out_data  (out_p),
    .state     (skid_state)
  );

  assign ex_alu_op   = out_p.alu_op;
  assign ex_alu_sel  = out_p.alu_sel;
  assign ex_reg0     = out_p.reg0;
  assign ex_reg1     = out_p.reg1;
  assign ex_waddr    = out_p.waddr;
  // A bubble must never write the register file, even though the payload is held.
  assign ex_wreg     = out_p.wreg & ex_valid;
  assign stage_state = skid_state;

endmodule
